// File: rtl/serializer16.sv
// -----------------------------------------------------------------------------
// serializer16 -- 16-bit parallel-to-serial transmitter
//
// Frame on sout: one start bit (0), 16 data bits, an optional even-parity bit,
// then STOP_BITS stop bits (1). The line idles high.
//
// Handshake: a word is accepted on a rising clock edge where load=1 and
// ready=1. ready is high only while idle; load while ready=0 is ignored and
// has no effect on the frame in progress.
//
// Parameters:
//   LSB_FIRST  1: in[0] is sent first, 0: in[15] is sent first
//   STOP_BITS  number of stop bits per frame (1 or 2)
//
// Optional feature:
//   SERIALIZER16_PARITY_EN  when defined, a one-cycle PARITY state carrying
//                           the XOR of the 16 data bits follows DATA.
//
// Ports:
//   clock  in   single clock, rising edge
//   reset  in   asynchronous, active-high
//   in     in   [15:0] parallel word
//   load   in   word valid
//   ready  out  word can be accepted (IDLE)
//   sout   out  serial line
//   busy   out  frame on the line
//   done   out  one-cycle pulse on the last stop bit
// -----------------------------------------------------------------------------
module serializer16 #(
    parameter int LSB_FIRST = 1,
    parameter int STOP_BITS = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    output logic        ready,
    output logic        sout,
    output logic        busy,
    output logic        done
);

`ifdef SERIALIZER16_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    // Index of the final stop cycle as counted by r_cnt inside STOP.
    localparam logic [3:0] LP_LAST_STOP = (STOP_BITS >= 2) ? 4'd1 : 4'd0;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_shift;
    logic [3:0]  r_cnt;
    logic [15:0] w_shift_rot;
    logic        w_data_bit;
    logic        w_last_stop;

    // The shift register rotates rather than shifts, so after the 16 data
    // cycles it holds the original word again; parity can then be taken from
    // it directly without a separate accumulator.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_data_bit  = r_shift[0];
            assign w_shift_rot = {r_shift[0], r_shift[15:1]};
        end else begin : g_msb_first
            assign w_data_bit  = r_shift[15];
            assign w_shift_rot = {r_shift[14:0], r_shift[15]};
        end
    endgenerate

    // r_cnt is reused in STOP to count stop cycles (it is 0 on entry, since
    // it wraps 15->0 when DATA ends).
    assign w_last_stop = (r_state == STOP) && (r_cnt == LP_LAST_STOP);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_next = START;
                end
            end
            START: begin
                w_next = DATA;
            end
            DATA: begin
                if (r_cnt == 4'd15) begin
`ifdef SERIALIZER16_PARITY_EN
                    w_next = PARITY;
`else
                    w_next = STOP;
`endif
                end
            end
`ifdef SERIALIZER16_PARITY_EN
            PARITY: begin
                w_next = STOP;
            end
`endif
            STOP: begin
                if (w_last_stop) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Datapath: shift register and bit/stop counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_shift <= in;
                        r_cnt   <= '0;
                    end
                end
                DATA: begin
                    r_shift <= w_shift_rot;
                    r_cnt   <= r_cnt + 4'd1;
                end
                STOP: begin
                    r_cnt <= w_last_stop ? 4'd0 : (r_cnt + 4'd1);
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from registered state only; reset forces IDLE
    // asynchronously, which drives the line high at once.
    always_comb begin
        sout  = 1'b1;
        busy  = 1'b1;
        ready = 1'b0;
        done  = 1'b0;
        case (r_state)
            IDLE: begin
                busy  = 1'b0;
                ready = 1'b1;
            end
            START: begin
                sout = 1'b0;
            end
            DATA: begin
                sout = w_data_bit;
            end
`ifdef SERIALIZER16_PARITY_EN
            PARITY: begin
                sout = ^r_shift;
            end
`endif
            STOP: begin
                done = w_last_stop;
            end
            default: begin
                busy  = 1'b0;
                ready = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_serializer16.sv
// -----------------------------------------------------------------------------
// tb_serializer16 -- bench for serializer16
//
// Two instances share clock, reset, in and load:
//   dut_a: LSB_FIRST=1, STOP_BITS=1
//   dut_b: LSB_FIRST=0, STOP_BITS=2
// Observed outputs are packed as {sout, busy, done, ready}.
// -----------------------------------------------------------------------------
module tb_serializer16;

    logic        clock;
    logic        reset;
    logic        load;
    logic [15:0] in_w;
    logic        a_ready, a_sout, a_busy, a_done;
    logic        b_ready, b_sout, b_busy, b_done;

`ifdef SERIALIZER16_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    localparam logic [3:0] IDLE_OBS = 4'b1001;

    serializer16 #(.LSB_FIRST(1), .STOP_BITS(1)) dut_a (
        .clock(clock), .reset(reset), .in(in_w), .load(load),
        .ready(a_ready), .sout(a_sout), .busy(a_busy), .done(a_done)
    );

    serializer16 #(.LSB_FIRST(0), .STOP_BITS(2)) dut_b (
        .clock(clock), .reset(reset), .in(in_w), .load(load),
        .ready(b_ready), .sout(b_sout), .busy(b_busy), .done(b_done)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: expected {sout,busy,done,ready} per cycle for each instance
    logic [3:0] exp_qa[$];
    logic [3:0] exp_qb[$];

    typedef struct {
        logic [15:0] word;
        logic [15:0] bits_lsb;  // dut_a send order, first bit at [15]
        logic [15:0] bits_msb;  // dut_b send order, first bit at [15]
        logic        par;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {sout,busy,done,ready}=%b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected outputs at cycle c after the accepting edge (c=1 is START).
    function automatic logic [3:0] exp_at(input int c, input logic [15:0] bits,
                                          input int stopn, input logic par);
        int len;
        int idx;
        len = 17 + PAR + stopn;
        if (c == 1) return 4'b0100;
        if (c <= 17) begin
            idx = 17 - c;
            return {bits[idx], 3'b100};
        end
        if (PAR == 1 && c == 18) return {par, 3'b100};
        if (c < len) return 4'b1100;
        if (c == len) return 4'b1110;
        return IDLE_OBS;
    endfunction

    // Driver: start at a falling edge, accept on the next rising edge, then
    // walk 21 cycles, scrambling in after acceptance.
    task automatic run_frame(input vec_t v, input string tag);
        in_w = v.word;
        load = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clock);
            check($sformatf("%s_a_c%0d", tag, c), {a_sout, a_busy, a_done, a_ready},
                  exp_at(c, v.bits_lsb, 1, v.par));
            check($sformatf("%s_b_c%0d", tag, c), {b_sout, b_busy, b_done, b_ready},
                  exp_at(c, v.bits_msb, 2, v.par));
            load = 1'b0;
            in_w = 16'($urandom);
        end
    endtask

    // Reference model: a frame is the list of line levels start, data in the
    // configured order, optional parity, stop bits.
    task automatic push_frame(input logic [15:0] w, input int lsb, input int stopn, input int which);
        logic [3:0] f[$];
        logic       bitv;
        f.push_back(4'b0100);
        for (int i = 0; i < 16; i++) begin
            bitv = (lsb != 0) ? w[i] : w[15 - i];
            f.push_back({bitv, 3'b100});
        end
        if (PAR == 1) f.push_back({logic'($countones(w) % 2), 3'b100});
        for (int s = 1; s <= stopn; s++) f.push_back({1'b1, 1'b1, (s == stopn), 1'b0});
        foreach (f[k]) begin
            if (which == 0) exp_qa.push_back(f[k]);
            else            exp_qb.push_back(f[k]);
        end
    endtask

    // mode 0: random load, 1: load held high, 2: load low (drain)
    task automatic run_model(input int n, input int mode, input string tag);
        logic [3:0] ea;
        logic [3:0] eb;
        int         last_acc;
        int         gaps;
        last_acc = -1;
        gaps     = 0;
        if (mode == 1) load = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(negedge clock);
            ea = (exp_qa.size() > 0) ? exp_qa.pop_front() : IDLE_OBS;
            eb = (exp_qb.size() > 0) ? exp_qb.pop_front() : IDLE_OBS;
            check($sformatf("%s_a_%0d", tag, c), {a_sout, a_busy, a_done, a_ready}, ea);
            check($sformatf("%s_b_%0d", tag, c), {b_sout, b_busy, b_done, b_ready}, eb);
            if (mode == 1 && b_ready === 1'b1) begin
                if (last_acc >= 0) begin
                    check_int($sformatf("%s_spacing_b", tag), c - last_acc, 17 + PAR + 2 + 1);
                    gaps++;
                end
                last_acc = c;
            end
            in_w = 16'($urandom);
            if (mode == 1)      load = 1'b1;
            else if (mode == 0) load = ($urandom_range(0, 3) == 0);
            else                load = 1'b0;
            if (load && ea[0]) push_frame(in_w, 1, 1, 0);
            if (load && eb[0]) push_frame(in_w, 0, 2, 1);
        end
        if (mode == 1) check_int($sformatf("%s_accepts_seen", tag), (gaps >= 2) ? 1 : 0, 1);
        load = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'hA5C3, 16'hC3A5, 16'hA5C3, 1'b0};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[3] = '{16'h0001, 16'h8000, 16'h0001, 1'b1};
        vecs[4] = '{16'h1234, 16'h2C48, 16'h1234, 1'b1};

        reset = 1'b1;
        load  = 1'b0;
        in_w  = '0;
        repeat (2) @(negedge clock);
        check("reset_a", {a_sout, a_busy, a_done, a_ready}, IDLE_OBS);
        check("reset_b", {b_sout, b_busy, b_done, b_ready}, IDLE_OBS);

        // load during reset has no effect
        load = 1'b1;
        in_w = 16'hFFFF;
        @(negedge clock);
        check("reset_load_a", {a_sout, a_busy, a_done, a_ready}, IDLE_OBS);
        check("reset_load_b", {b_sout, b_busy, b_done, b_ready}, IDLE_OBS);
        load = 1'b0;

        // Release and load in the same cycle: accept on first edge after reset
        reset = 1'b0;
        foreach (vecs[i]) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted on data bit 7 (cycle 9), checked before any clock edge
        in_w = 16'h3C5A;
        load = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            load = 1'b0;
            in_w = 16'($urandom);
        end
        check("pre_abort_busy_a", {1'b0, a_busy, 2'b00}, 4'b0100);
        #2 reset = 1'b1;
        #1;
        check("async_rst_a", {a_sout, a_busy, a_done, a_ready}, IDLE_OBS);
        check("async_rst_b", {b_sout, b_busy, b_done, b_ready}, IDLE_OBS);
        @(negedge clock);
        @(negedge clock);
        check("held_rst_a", {a_sout, a_busy, a_done, a_ready}, IDLE_OBS);
        check("held_rst_b", {b_sout, b_busy, b_done, b_ready}, IDLE_OBS);
        reset = 1'b0;
        run_frame(vecs[4], "after_rst");

        // Randomized traffic against the model
        run_model(400, 0, "rand");
        run_model(70, 1, "cont");
        run_model(25, 2, "drain");
        check_int("drain_qa_empty", exp_qa.size(), 0);
        check_int("drain_qb_empty", exp_qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
